// File: rtl/fetch_sequencer.sv
// Control sequencer for the instruction-fetch datapath: steps PC/ROM/IR through
// fetch, decode and an optional execute-unit handshake with a watchdog.
module fetch_sequencer #(
    parameter int unsigned RomWait     = 1,
    parameter int unsigned ExecTimeout = 255
) (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        run_i,
    input  logic [11:0] ir_i,
    input  logic        zf_i,
    input  logic        exec_done_i,
    output logic        rom_oe_o,
    output logic        ir_en_o,
    output logic        pc_en_o,
    output logic        pc_sel_o,
    output logic        exec_start_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StHalted = 3'd4;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpJmp  = 3'b001;
    localparam logic [2:0] OpJz   = 3'b010;
    localparam logic [2:0] OpHalt = 3'b011;

    // Counter only needs to reach ExecTimeout-1; a zero timeout disables the watchdog.
    localparam int unsigned   TmoW     = (ExecTimeout > 1) ? $clog2(ExecTimeout) : 1;
    localparam bit            TmoEn    = (ExecTimeout != 0);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ExecTimeout - 1);
    localparam logic [3:0]    WaitLast = 4'(RomWait - 1);

    logic [2:0]      state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            fault_q, fault_d;
    logic [2:0]      opcode;
    logic [2:0]      state_after;

    assign opcode      = ir_i[11:9];
    assign state_after = run_i ? StFetch : StIdle;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        fault_d      = fault_q;
        rom_oe_o     = 1'b0;
        ir_en_o      = 1'b0;
        pc_en_o      = 1'b0;
        pc_sel_o     = 1'b0;
        exec_start_o = 1'b0;
        halted_o     = 1'b0;

        case (state_q)
            StIdle: begin
                wait_d = '0;
                tmo_d  = '0;
                if (run_i) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                rom_oe_o = 1'b1;
                if (wait_q == WaitLast) begin
                    ir_en_o = 1'b1;
                    wait_d  = '0;
                    state_d = StDecode;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            StDecode: begin
                tmo_d = '0;
                case (opcode)
                    OpNop: begin
                        pc_en_o = 1'b1;
                        state_d = state_after;
                    end
                    OpJmp: begin
                        pc_en_o  = 1'b1;
                        pc_sel_o = 1'b1;
                        state_d  = state_after;
                    end
                    OpJz: begin
                        pc_en_o  = 1'b1;
                        pc_sel_o = zf_i;
                        state_d  = state_after;
                    end
                    OpHalt: begin
                        state_d = StHalted;
                    end
                    default: begin
                        exec_start_o = 1'b1;
                        state_d      = StExec;
                    end
                endcase
            end

            StExec: begin
                // Done wins over a watchdog expiry landing in the same cycle.
                if (exec_done_i) begin
                    pc_en_o = 1'b1;
                    tmo_d   = '0;
                    state_d = state_after;
                end else if (TmoEn && (tmo_q == TmoLast)) begin
                    fault_d = 1'b1;
                    state_d = StHalted;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            StHalted: begin
                halted_o = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= StIdle;
            wait_q  <= '0;
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios, then random instruction streams
// checked against an instruction-level plan of expected per-cycle outputs.
module tb_fetch_sequencer;

    localparam int RW = 1;
    localparam int TO = 4;
    localparam int MIdle = 0;
    localparam int MBusy = 1;
    localparam int MHalt = 2;

    typedef struct packed {
        logic        run;
        logic [11:0] ir;
        logic        zf;
        logic        done;
        logic [9:0]  exp;
    } step_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic [11:0] ir = 12'h000;
    logic        zf = 1'b0;
    logic        exec_done = 1'b0;
    logic        rom_oe, ir_en, pc_en, pc_sel, exec_start, halted, fault;
    logic [2:0]  state;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [9:0]  obs_last;
    int          pen_cnt;
    int          xs_cnt;
    step_t       plan[$];
    step_t       s_cur;
    int          mode, next_mode, halt_left;
    logic        flt_m, next_fault, rnd_r;

    fetch_sequencer #(
        .RomWait     (RW),
        .ExecTimeout (TO)
    ) dut (
        .clk_i        (clk),
        .clr_i        (clr),
        .run_i        (run),
        .ir_i         (ir),
        .zf_i         (zf),
        .exec_done_i  (exec_done),
        .rom_oe_o     (rom_oe),
        .ir_en_o      (ir_en),
        .pc_en_o      (pc_en),
        .pc_sel_o     (pc_sel),
        .exec_start_o (exec_start),
        .halted_o     (halted),
        .fault_o      (fault),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ev(input logic [2:0] st, input logic flt, input logic hlt,
                                      input logic xs, input logic sel, input logic pen,
                                      input logic iren, input logic oe);
        return {st, flt, hlt, xs, sel, pen, iren, oe};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [11:0] rir();
        return 12'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle's inputs just after the edge, sample before the next edge.
    task automatic tick(input logic t_run, input logic t_clr, input logic [11:0] t_ir,
                        input logic t_zf, input logic t_done, input logic [9:0] t_exp,
                        input string tag);
        run = t_run;
        clr = t_clr;
        ir = t_ir;
        zf = t_zf;
        exec_done = t_done;
        #3;
        obs_last = {state, fault, halted, exec_start, pc_sel, pc_en, ir_en, rom_oe};
        pen_cnt += int'(pc_en);
        xs_cnt += int'(exec_start);
        chk(tag, 32'(obs_last), 32'(t_exp));
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    task automatic build_instr();
        step_t      s;
        logic [2:0] op;
        logic       zfv;
        logic       endrun;
        int         k;
        op = 3'($urandom_range(0, 7));
        zfv = rb();
        endrun = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < RW; i++) begin
            s.run = rb();
            s.ir = rir();
            s.zf = rb();
            s.done = rb();
            s.exp = ev(3'd1, 0, 0, 0, 0, 0, (i == RW - 1), 1);
            plan.push_back(s);
        end
        s.ir = {op, 9'($urandom)};
        s.zf = zfv;
        s.done = rb();
        s.run = (op < 3) ? endrun : rb();
        next_fault = 1'b0;
        case (op)
            3'd0:    s.exp = ev(3'd2, 0, 0, 0, 0, 1, 0, 0);
            3'd1:    s.exp = ev(3'd2, 0, 0, 0, 1, 1, 0, 0);
            3'd2:    s.exp = ev(3'd2, 0, 0, 0, zfv, 1, 0, 0);
            3'd3:    s.exp = ev(3'd2, 0, 0, 0, 0, 0, 0, 0);
            default: s.exp = ev(3'd2, 0, 0, 1, 0, 0, 0, 0);
        endcase
        plan.push_back(s);
        if (op < 3) begin
            next_mode = endrun ? MBusy : MIdle;
        end else if (op == 3) begin
            next_mode = MHalt;
            halt_left = $urandom_range(1, 4);
        end else begin
            k = $urandom_range(1, TO + 2);
            for (int c = 1; c <= TO && c <= k; c++) begin
                s.done = (c == k);
                s.run = (c == k) ? endrun : rb();
                s.ir = rir();
                s.zf = rb();
                s.exp = ev(3'd3, 0, 0, 0, 0, (c == k), 0, 0);
                plan.push_back(s);
            end
            if (k <= TO) begin
                next_mode = endrun ? MBusy : MIdle;
            end else begin
                next_mode = MHalt;
                next_fault = 1'b1;
                halt_left = $urandom_range(1, 4);
            end
        end
    endtask

    initial begin
        pen_cnt = 0;
        xs_cnt = 0;
        #2 clr = 1'b1;
        @(posedge clk);
        #1;

        // Reset and idle hold
        tick(1, 1, 12'h812, 1, 1, 10'h000, "reset_outputs_zero");
        for (int i = 0; i < 10; i++) tick(0, 0, 12'h000, 0, 0, 10'h000, "idle_hold");

        // Sequential NOP stream
        tick(1, 0, 12'h000, 0, 0, 10'h000, "seq_idle");
        pen_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 12'h000, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "seq_fetch");
            tick((i != 9), 0, 12'h000, 0, 0, ev(3'd2, 0, 0, 0, 0, 1, 0, 0), "seq_decode");
        end
        chk("seq_retired_in_20", 32'(pen_cnt), 32'd10);
        tick(0, 0, 12'h000, 0, 0, 10'h000, "seq_back_idle");

        // Jumps
        tick(1, 0, 12'h23C, 0, 0, 10'h000, "jmp_idle");
        tick(1, 0, 12'h23C, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "jmp_fetch");
        tick(0, 0, 12'h23C, 0, 0, ev(3'd2, 0, 0, 0, 1, 1, 0, 0), "jmp_decode");
        tick(1, 0, 12'h405, 0, 0, 10'h000, "jz0_idle");
        tick(1, 0, 12'h405, 1, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "jz0_fetch");
        tick(0, 0, 12'h405, 0, 0, ev(3'd2, 0, 0, 0, 0, 1, 0, 0), "jz_zf0_decode");
        tick(1, 0, 12'h405, 0, 0, 10'h000, "jz1_idle");
        tick(1, 0, 12'h405, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "jz1_fetch");
        tick(0, 0, 12'h405, 1, 0, ev(3'd2, 0, 0, 0, 1, 1, 0, 0), "jz_zf1_decode");

        // Execute handshake, done on third EXEC cycle
        tick(1, 0, 12'h812, 0, 0, 10'h000, "exec_idle");
        xs_cnt = 0;
        pen_cnt = 0;
        tick(1, 0, 12'h812, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "exec_fetch");
        tick(1, 0, 12'h812, 0, 0, ev(3'd2, 0, 0, 1, 0, 0, 0, 0), "exec_decode");
        tick(1, 0, 12'h812, 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "exec_wait1");
        tick(1, 0, 12'h812, 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "exec_wait2");
        tick(1, 0, 12'h812, 0, 1, ev(3'd3, 0, 0, 0, 0, 1, 0, 0), "exec_done");
        tick(1, 0, 12'h000, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "exec_next_fetch");
        chk("exec_start_one_pulse", 32'(xs_cnt), 32'd1);
        chk("exec_pc_en_once", 32'(pen_cnt), 32'd1);
        tick(0, 0, 12'h000, 0, 0, ev(3'd2, 0, 0, 0, 0, 1, 0, 0), "exec_next_decode");

        // Done coincident with watchdog expiry counts as done
        tick(1, 0, 12'h812, 0, 0, 10'h000, "edge_idle");
        tick(1, 0, 12'h812, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "edge_fetch");
        tick(1, 0, 12'h812, 0, 0, ev(3'd2, 0, 0, 1, 0, 0, 0, 0), "edge_decode");
        for (int i = 0; i < 3; i++)
            tick(1, 0, 12'h812, 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "edge_wait");
        tick(0, 0, 12'h812, 0, 1, ev(3'd3, 0, 0, 0, 0, 1, 0, 0), "edge_done_at_limit");
        tick(0, 0, 12'h000, 0, 0, 10'h000, "edge_no_fault");

        // Timeout
        tick(1, 0, 12'hA00, 0, 0, 10'h000, "tmo_idle");
        tick(1, 0, 12'hA00, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "tmo_fetch");
        tick(1, 0, 12'hA00, 0, 0, ev(3'd2, 0, 0, 1, 0, 0, 0, 0), "tmo_decode");
        for (int i = 0; i < 4; i++)
            tick(1, 0, 12'hA00, 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "tmo_wait");
        for (int i = 0; i < 5; i++)
            tick(1, 0, 12'hA00, 0, 1, ev(3'd4, 1, 1, 0, 0, 0, 0, 0), "tmo_halted_sticky");
        tick(1, 1, 12'hA00, 0, 0, 10'h000, "tmo_clr");
        tick(0, 0, 12'h000, 0, 0, 10'h000, "tmo_after_clr");

        // HALT opcode
        tick(1, 0, 12'h600, 0, 0, 10'h000, "halt_idle");
        tick(1, 0, 12'h600, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "halt_fetch");
        tick(1, 0, 12'h600, 1, 0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "halt_decode");
        for (int i = 0; i < 3; i++)
            tick(1, 0, 12'h600, 0, 0, ev(3'd4, 0, 1, 0, 0, 0, 0, 0), "halt_stays");
        tick(0, 1, 12'h000, 0, 0, 10'h000, "halt_clr");

        // RUN dropped during FETCH still completes the NOP
        tick(1, 0, 12'h000, 0, 0, 10'h000, "drop_idle");
        tick(0, 0, 12'h000, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "drop_fetch");
        tick(0, 0, 12'h000, 0, 0, ev(3'd2, 0, 0, 0, 0, 1, 0, 0), "drop_decode_pc_en");
        tick(0, 0, 12'h000, 0, 0, 10'h000, "drop_idle_after");

        // 0xFFF is an execute opcode
        tick(1, 0, 12'hFFF, 0, 0, 10'h000, "fff_idle");
        tick(1, 0, 12'hFFF, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "fff_fetch");
        tick(0, 0, 12'hFFF, 0, 0, ev(3'd2, 0, 0, 1, 0, 0, 0, 0), "fff_decode_exec");
        tick(0, 0, 12'hFFF, 0, 1, ev(3'd3, 0, 0, 0, 0, 1, 0, 0), "fff_done");
        tick(0, 0, 12'h000, 0, 0, 10'h000, "fff_idle_after");

        // CLR in the middle of EXEC with done pending
        tick(1, 0, 12'h812, 0, 0, 10'h000, "mid_idle");
        tick(1, 0, 12'h812, 0, 0, ev(3'd1, 0, 0, 0, 0, 0, 1, 1), "mid_fetch");
        tick(1, 0, 12'h812, 0, 0, ev(3'd2, 0, 0, 1, 0, 0, 0, 0), "mid_decode");
        tick(1, 0, 12'h812, 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0), "mid_exec");
        tick(1, 1, 12'h812, 1, 1, 10'h000, "mid_exec_clr");
        tick(0, 0, 12'h812, 0, 1, 10'h000, "mid_done_discarded");

        // Random instruction streams
        mode = MIdle;
        flt_m = 1'b0;
        plan.delete();
        for (int n = 0; n < 2500; n++) begin
            if (mode == MHalt) begin
                if (halt_left == 0) begin
                    tick(rb(), 1, rir(), rb(), rb(), 10'h000, "rnd_clr_halted");
                    mode = MIdle;
                    flt_m = 1'b0;
                end else begin
                    tick(rb(), 0, rir(), rb(), rb(), ev(3'd4, flt_m, 1, 0, 0, 0, 0, 0),
                         "rnd_halted");
                    halt_left--;
                end
            end else if ($urandom_range(0, 59) == 0) begin
                tick(rb(), 1, rir(), rb(), rb(), 10'h000, "rnd_clr");
                plan.delete();
                mode = MIdle;
                flt_m = 1'b0;
            end else if (mode == MIdle) begin
                rnd_r = rb();
                tick(rnd_r, 0, rir(), rb(), rb(), ev(3'd0, flt_m, 0, 0, 0, 0, 0, 0), "rnd_idle");
                if (rnd_r) begin
                    mode = MBusy;
                    build_instr();
                end
            end else begin
                s_cur = plan.pop_front();
                tick(s_cur.run, 0, s_cur.ir, s_cur.zf, s_cur.done, s_cur.exp, "rnd_step");
                if (plan.size() == 0) begin
                    mode = next_mode;
                    flt_m = next_fault;
                    if (mode == MBusy) build_instr();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
